// File: rtl/snd_pkg.sv
// snd_pkg: shared constants for the sound command block.
//   VEC_*      : IM0 RST vector construction (all-ones with per-source bits cleared)
//   PORT_*     : Z80 IO port addresses decoded by the surrounding sound block
//   irq_vector : builds the IM0 opcode from the two pending flags
package snd_pkg;
    localparam logic [7:0] VEC_NONE    = 8'hFF;
    localparam int         VEC_YM_BIT  = 4;
    localparam int         VEC_CMD_BIT = 5;
    localparam logic [7:0] PORT_CMD    = 8'h80;
    localparam logic [7:0] PORT_ACK    = 8'h82;
    localparam logic [7:0] PORT_REPLY  = 8'h83;

    // ym only -> EFh (RST 28h), cmd only -> DFh (RST 18h), both -> CFh
    function automatic logic [7:0] irq_vector(input logic ym, input logic cmd);
        logic [7:0] v;
        v = VEC_NONE;
        v[VEC_YM_BIT]  = ~ym;
        v[VEC_CMD_BIT] = ~cmd;
        return v;
    endfunction
endpackage

// File: rtl/snd_latch_irq_if.sv
// snd_latch_irq_if: main-CPU and Z80 side signals of the sound command latch.
//   main_* : command write, reply read-back, full flag (main CPU side)
//   z80_*  : command head, ack, reply write, INT and IM0 vector (Z80 side)
//   ym_irq_n : YM2151 interrupt request, active-low
// slave is the latch itself, master is whatever drives the strobes.
interface snd_latch_irq_if;
    logic       main_wr;
    logic [7:0] main_din;
    logic       main_rd;
    logic [7:0] main_dout;
    logic       main_rdy;
    logic       main_full;
    logic [7:0] z80_cmd_dout;
    logic       z80_ack;
    logic       z80_reply_wr;
    logic [7:0] z80_reply_din;
    logic       ym_irq_n;
    logic       z80_intack;
    logic       z80_int_n;
    logic [7:0] z80_vector;

    modport slave (
        input  main_wr, main_din, main_rd, z80_ack, z80_reply_wr, z80_reply_din,
               ym_irq_n, z80_intack,
        output main_dout, main_rdy, main_full, z80_cmd_dout, z80_int_n, z80_vector
    );
    modport master (
        output main_wr, main_din, main_rd, z80_ack, z80_reply_wr, z80_reply_din,
               ym_irq_n, z80_intack,
        input  main_dout, main_rdy, main_full, z80_cmd_dout, z80_int_n, z80_vector
    );
endinterface

// File: rtl/snd_cmd_fifo.sv
// snd_cmd_fifo: command byte FIFO with overwrite-newest-on-full.
//   clk_sys : clock            i_clr  : synchronous clear (pointers/count to 0)
//   i_push  : append i_din     i_pop  : drop head (ignored when empty)
//   o_head  : head entry, combinational
//   o_count : occupancy        o_full : registered count==DEPTH
module snd_cmd_fifo #(
    parameter int DEPTH = 1
) (
    input  logic                   clk_sys,
    input  logic                   i_clr,
    input  logic                   i_push,
    input  logic [7:0]             i_din,
    input  logic                   i_pop,
    output logic [7:0]             o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    // pointers stay at 0 when DEPTH=1; the spare slot of r_mem is never addressed
    function automatic logic [PW-1:0] step(input logic [PW-1:0] p, input logic up);
        return (DEPTH == 1) ? '0 : (up ? p + PW'(1) : p - PW'(1));
    endfunction

    logic [7:0]    r_mem [2**PW];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          w_pop, w_ovr, w_wr_adv;
    logic [PW-1:0] w_wr_idx;
    logic [CW-1:0] w_cnt_nxt;

    // full with no pop: the newest entry is replaced in place;
    // full with a pop: the freed slot takes the byte as a normal append
    assign w_pop     = i_pop && (r_count != '0);
    assign w_ovr     = i_push && r_full && !w_pop;
    assign w_wr_adv  = i_push && !w_ovr;
    assign w_wr_idx  = w_ovr ? step(r_wr_ptr, 1'b0) : r_wr_ptr;
    assign w_cnt_nxt = (w_wr_adv && !w_pop) ? r_count + CW'(1) :
                       (w_pop && !i_push)   ? r_count - CW'(1) : r_count;

    always_ff @(posedge clk_sys) begin
        if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (i_push)   r_mem[w_wr_idx] <= i_din;
            if (w_wr_adv) r_wr_ptr <= step(r_wr_ptr, 1'b1);
            if (w_pop)    r_rd_ptr <= step(r_rd_ptr, 1'b1);
            r_count <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == CW'(DEPTH));
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = r_full;
endmodule

// File: rtl/snd_latch_irq.sv
// snd_latch_irq: sound-side responder for the main CPU command interface.
//   clk_sys   : system clock
//   reset_n   : synchronous active-low reset
//   snd_reset : synchronous clear, same effect as reset_n low
//   bus       : snd_latch_irq_if.slave (command FIFO, reply latch, Z80 INT/vector)
module snd_latch_irq
    import snd_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic           clk_sys,
    input  logic           reset_n,
    input  logic           snd_reset,
    snd_latch_irq_if.slave bus
);
    logic                   w_rst, w_wr_rise, w_rd_fall, w_ia_rise, w_cmd_pend;
    logic [$clog2(DEPTH):0] w_count;
    logic [7:0]             w_vec;
    logic                   r_wr_d, r_rd_d, r_ia_d, r_push, r_ym_s1, r_ym_s2, r_int_n, r_rdy;
    logic [7:0]             r_push_din, r_vec, r_dout;

    assign w_rst      = !reset_n || snd_reset;
    assign w_wr_rise  = bus.main_wr && !r_wr_d;
    assign w_rd_fall  = !bus.main_rd && r_rd_d;
    assign w_ia_rise  = bus.z80_intack && !r_ia_d;
    assign w_cmd_pend = (w_count != '0);
    assign w_vec      = irq_vector(r_ym_s2, w_cmd_pend);

    snd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_sys (clk_sys),
        .i_clr   (w_rst),
        .i_push  (r_push),
        .i_din   (r_push_din),
        .i_pop   (bus.z80_ack),
        .o_head  (bus.z80_cmd_dout),
        .o_count (w_count),
        .o_full  (bus.main_full)
    );

    // During reset the edge detectors follow their strobes, so a level held
    // through reset release is not seen as a new edge.
    always_ff @(posedge clk_sys) begin
        if (w_rst) begin
            r_wr_d     <= bus.main_wr;
            r_rd_d     <= bus.main_rd;
            r_ia_d     <= bus.z80_intack;
            r_push     <= 1'b0;
            r_push_din <= '0;
            r_ym_s1    <= 1'b0;
            r_ym_s2    <= 1'b0;
            r_int_n    <= 1'b1;
            r_vec      <= VEC_NONE;
            r_dout     <= '0;
            r_rdy      <= 1'b0;
        end else begin
            r_wr_d     <= bus.main_wr;
            r_rd_d     <= bus.main_rd;
            r_ia_d     <= bus.z80_intack;
            r_push     <= w_wr_rise;
            r_push_din <= bus.main_din;
            r_ym_s1    <= !bus.ym_irq_n;
            r_ym_s2    <= r_ym_s1;
            r_int_n    <= !(w_cmd_pend || r_ym_s2);
            if (w_ia_rise) r_vec <= w_vec;
            // a reply write beats the read-strobe falling edge
            if (bus.z80_reply_wr) begin
                r_dout <= bus.z80_reply_din;
                r_rdy  <= 1'b1;
            end else if (w_rd_fall) begin
                r_rdy  <= 1'b0;
            end
        end
    end

    assign bus.main_dout  = r_dout;
    assign bus.main_rdy   = r_rdy;
    assign bus.z80_int_n  = r_int_n;
    assign bus.z80_vector = r_vec;
endmodule

// File: tb/tb_snd_latch_irq.sv
// tb_snd_latch_irq: checks DEPTH=4 and DEPTH=1 instances side by side against a queue model.
module tb_snd_latch_irq;
    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0, snd_reset = 1'b0;
    logic       main_wr = 1'b1, main_rd = 1'b0, z80_ack = 1'b0, z80_reply_wr = 1'b0;
    logic       ym_irq_n = 1'b1, z80_intack = 1'b0;
    logic [7:0] main_din = '0, z80_reply_din = '0;
    int         n_tests = 0, n_fail = 0;

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_d
        localparam int D = (g == 0) ? 4 : 1;
        snd_latch_irq_if bus ();
        assign bus.main_wr       = main_wr;
        assign bus.main_din      = main_din;
        assign bus.main_rd       = main_rd;
        assign bus.z80_ack       = z80_ack;
        assign bus.z80_reply_wr  = z80_reply_wr;
        assign bus.z80_reply_din = z80_reply_din;
        assign bus.ym_irq_n      = ym_irq_n;
        assign bus.z80_intack    = z80_intack;

        snd_latch_irq #(.DEPTH(D)) dut (
            .clk_sys   (clk_sys),
            .reset_n   (reset_n),
            .snd_reset (snd_reset),
            .bus       (bus.slave)
        );

        logic [7:0] q[$];
        logic       pend = 1'b0, ym1 = 1'b0, ym2 = 1'b0, int_n = 1'b1, rdy = 1'b0;
        logic       pwr = 1'b0, prd = 1'b0, pia = 1'b0, cmd, ym;
        logic [7:0] pend_b = '0, vec = 8'hFF, dout = '0;

        always @(posedge clk_sys) begin
            if (!reset_n || snd_reset) begin
                q.delete();
                pend = 1'b0;
                ym1 = 1'b0;
                ym2 = 1'b0;
                int_n = 1'b1;
                vec = 8'hFF;
                rdy = 1'b0;
                dout = '0;
            end else begin
                cmd = (q.size() > 0);
                ym = ym2;
                int_n = !(cmd || ym);
                if (z80_intack && !pia) begin
                    vec = 8'hFF;
                    if (ym) vec[4] = 1'b0;
                    if (cmd) vec[5] = 1'b0;
                end
                if (z80_ack && q.size() > 0) void'(q.pop_front());
                if (pend) begin
                    if (q.size() == D) q[q.size()-1] = pend_b;
                    else q.push_back(pend_b);
                end
                pend = main_wr && !pwr;
                pend_b = main_din;
                ym2 = ym1;
                ym1 = !ym_irq_n;
                if (z80_reply_wr) begin
                    dout = z80_reply_din;
                    rdy = 1'b1;
                end else if (!main_rd && prd) rdy = 1'b0;
            end
            pwr = main_wr;
            prd = main_rd;
            pia = z80_intack;
            #1;
            chk($sformatf("d%0d_full", D), bus.main_full, (q.size() == D));
            chk($sformatf("d%0d_int_n", D), bus.z80_int_n, int_n);
            chk($sformatf("d%0d_vector", D), bus.z80_vector, vec);
            chk($sformatf("d%0d_rdy", D), bus.main_rdy, rdy);
            chk($sformatf("d%0d_dout", D), bus.main_dout, dout);
            if (q.size() > 0) chk($sformatf("d%0d_cmd_dout", D), bus.z80_cmd_dout, q[0]);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic wr_byte(input logic [7:0] b);
        main_din = b;
        main_wr = 1'b1;
        cyc(1);
        main_wr = 1'b0;
        cyc(1);
    endtask

    task automatic ack();
        z80_ack = 1'b1;
        cyc(1);
        z80_ack = 1'b0;
    endtask

    task automatic intack_pulse();
        z80_intack = 1'b1;
        cyc(1);
        z80_intack = 1'b0;
    endtask

    initial begin
        // reset with main_wr held high, then released while still high
        cyc(3);
        reset_n = 1'b1;
        cyc(3);
        chk("rst_full4", g_d[0].bus.main_full, 0);
        chk("rst_full1", g_d[1].bus.main_full, 0);
        chk("rst_int_n", g_d[0].bus.z80_int_n, 1);
        chk("rst_vector", g_d[0].bus.z80_vector, 8'hFF);
        chk("rst_rdy", g_d[0].bus.main_rdy, 0);
        main_wr = 1'b0;
        cyc(1);
        main_din = 8'h5A;
        main_wr = 1'b1;
        cyc(1);
        chk("edge_int_n", g_d[0].bus.z80_int_n, 1);
        main_wr = 1'b0;
        cyc(1);
        chk("push_dout", g_d[0].bus.z80_cmd_dout, 8'h5A);
        chk("push_full1", g_d[1].bus.main_full, 1);
        chk("push_int_n_lag", g_d[0].bus.z80_int_n, 1);
        cyc(1);
        chk("push_int_n", g_d[0].bus.z80_int_n, 0);
        ack();
        cyc(1);
        chk("drain_int_n4", g_d[0].bus.z80_int_n, 1);
        chk("drain_int_n1", g_d[1].bus.z80_int_n, 1);

        // DEPTH=1 overwrite
        wr_byte(8'h11);
        wr_byte(8'h22);
        chk("d1_ovr_dout", g_d[1].bus.z80_cmd_dout, 8'h22);
        chk("d1_ovr_full", g_d[1].bus.main_full, 1);
        chk("d4_head", g_d[0].bus.z80_cmd_dout, 8'h11);
        ack();
        chk("d1_ack_full", g_d[1].bus.main_full, 0);
        cyc(1);
        chk("d1_ack_int_n", g_d[1].bus.z80_int_n, 1);
        chk("d4_still_int", g_d[0].bus.z80_int_n, 0);
        ack();
        cyc(1);

        // DEPTH=4 overwrite on full, then push coinciding with pop
        for (int i = 1; i <= 5; i++) wr_byte(8'(i));
        chk("d4_full", g_d[0].bus.main_full, 1);
        chk("d4_head01", g_d[0].bus.z80_cmd_dout, 8'h01);
        main_din = 8'h06;
        main_wr = 1'b1;
        cyc(1);
        main_wr = 1'b0;
        z80_ack = 1'b1;
        cyc(1);
        z80_ack = 1'b0;
        chk("d4_pp_full", g_d[0].bus.main_full, 1);
        chk("d1_pp_dout", g_d[1].bus.z80_cmd_dout, 8'h06);
        chk("d4_h02", g_d[0].bus.z80_cmd_dout, 8'h02);
        ack();
        chk("d4_h03", g_d[0].bus.z80_cmd_dout, 8'h03);
        ack();
        chk("d4_h05", g_d[0].bus.z80_cmd_dout, 8'h05);
        ack();
        chk("d4_h06", g_d[0].bus.z80_cmd_dout, 8'h06);
        ack();
        chk("d4_empty_full", g_d[0].bus.main_full, 0);
        ack();
        cyc(1);
        chk("d4_empty_int_n", g_d[0].bus.z80_int_n, 1);

        // interrupt vector merging
        wr_byte(8'h77);
        ym_irq_n = 1'b0;
        cyc(3);
        intack_pulse();
        chk("vec_both", g_d[0].bus.z80_vector, 8'hCF);
        ack();
        cyc(1);
        intack_pulse();
        chk("vec_ym", g_d[0].bus.z80_vector, 8'hEF);
        chk("ym_int_n", g_d[0].bus.z80_int_n, 0);
        ym_irq_n = 1'b1;
        cyc(3);
        chk("ym_rel_int_n", g_d[0].bus.z80_int_n, 1);
        intack_pulse();
        chk("vec_none", g_d[0].bus.z80_vector, 8'hFF);

        // reply path
        z80_reply_din = 8'hA5;
        z80_reply_wr = 1'b1;
        cyc(1);
        z80_reply_wr = 1'b0;
        chk("rep_rdy", g_d[0].bus.main_rdy, 1);
        chk("rep_dout", g_d[0].bus.main_dout, 8'hA5);
        main_rd = 1'b1;
        cyc(6);
        chk("rep_hold", g_d[0].bus.main_rdy, 1);
        main_rd = 1'b0;
        cyc(1);
        chk("rep_clr", g_d[0].bus.main_rdy, 0);
        main_rd = 1'b1;
        cyc(2);
        main_rd = 1'b0;
        z80_reply_din = 8'hC3;
        z80_reply_wr = 1'b1;
        cyc(1);
        z80_reply_wr = 1'b0;
        chk("rep_win_rdy", g_d[0].bus.main_rdy, 1);
        chk("rep_win_dout", g_d[0].bus.main_dout, 8'hC3);

        // snd_reset with commands queued and a reply pending
        wr_byte(8'hA1);
        wr_byte(8'hA2);
        wr_byte(8'hA3);
        z80_reply_din = 8'h99;
        z80_reply_wr = 1'b1;
        cyc(1);
        z80_reply_wr = 1'b0;
        intack_pulse();
        chk("pre_sr_vec", g_d[0].bus.z80_vector, 8'hDF);
        snd_reset = 1'b1;
        cyc(1);
        snd_reset = 1'b0;
        chk("sr_full1", g_d[1].bus.main_full, 0);
        chk("sr_rdy", g_d[0].bus.main_rdy, 0);
        chk("sr_int_n", g_d[0].bus.z80_int_n, 1);
        chk("sr_vec", g_d[0].bus.z80_vector, 8'hFF);
        chk("sr_dout", g_d[0].bus.main_dout, 8'h00);

        // randomized traffic, the compare processes check every cycle
        for (int i = 0; i < 3000; i++) begin
            snd_reset     = ($urandom_range(0, 199) == 0);
            reset_n       = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 2) == 0) main_wr = ~main_wr;
            main_din      = 8'($urandom);
            if ($urandom_range(0, 3) == 0) main_rd = ~main_rd;
            z80_ack       = ($urandom_range(0, 3) == 0);
            z80_reply_wr  = ($urandom_range(0, 5) == 0);
            z80_reply_din = 8'($urandom);
            if ($urandom_range(0, 19) == 0) ym_irq_n = ~ym_irq_n;
            if ($urandom_range(0, 2) == 0) z80_intack = ~z80_intack;
            cyc(1);
        end
        reset_n = 1'b1;
        snd_reset = 1'b0;
        cyc(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
